mem_request_unit: RTL and testbench
===================================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles in REQ without ack before error.
REQ-002 SHALL have port hwclk  in  1  sole clock, rising-edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  CPU request strobe.
REQ-005 SHALL have port req_write  in  1  1=store, 0=load.
REQ-006 SHALL have port req_dbl  in  1  1=16-bit access, 0=8-bit.
REQ-007 SHALL have port req_addr  in  16  byte address.
REQ-008 SHALL have port req_wdata  in  16  store data.
REQ-009 SHALL have port req_ready  out  1  high only in IDLE.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  out  16  load result.
REQ-012 SHALL have port rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-013 SHALL have port mem_read_en  out  1  read request to memory controller.
REQ-014 SHALL have port mem_write_en  out  1  write request to memory controller.
REQ-015 SHALL have port dbl_byte_en  out  1  16-bit request qualifier.
REQ-016 SHALL have port address  out  16  request address.
REQ-017 SHALL have port data_in  out  16  write data to controller.
REQ-018 SHALL have port ack  in  1  controller completion.
REQ-019 SHALL have port data_output  in  16  controller read data.

Function
REQ-020 SHALL implement states IDLE, REQ, RELEASE; all outputs registered.
REQ-021 IDLE: req_valid high at edge SHALL capture req_* into holding registers and enter REQ.
REQ-022 REQ SHALL drive mem_read_en=~write, mem_write_en=write, dbl_byte_en, address, data_in from holding registers; enables go high the cycle after acceptance.
REQ-023 Changes on req_* after acceptance SHALL NOT affect the outstanding request.
REQ-024 REQ: ack high at edge SHALL enter RELEASE with rsp_err=0; load captures rsp_rdata = dbl ? data_output : {8'h00, data_output[7:0]}; store sets rsp_rdata=0.
REQ-025 REQ: wait counter SHALL start at 0 on entry and increment each cycle without ack; reaching TIMEOUT_CYCLES-1 with no ack SHALL enter RELEASE with rsp_err=1, rsp_rdata=0.
REQ-026 Ack and timeout on the same edge: ack wins, rsp_err=0.
REQ-027 RELEASE SHALL last exactly one cycle with all enables low and address/data_in 0, rsp_valid=1, then return to IDLE.
REQ-028 rsp_valid SHALL be high only in RELEASE; rsp_rdata/rsp_err hold until next completion.
REQ-029 req_valid outside IDLE SHALL be ignored (req_ready=0); back-to-back minimum request period is 3 cycles plus ack latency.
REQ-030 ack outside REQ SHALL be ignored.
REQ-031 Outside REQ, mem_read_en, mem_write_en, dbl_byte_en SHALL be 0.

Reset
REQ-032 reset SHALL force IDLE at the next edge regardless of state, aborting any request without rsp_valid.
REQ-033 Reset values: req_ready=1, every other output 0, counter 0, holding registers 0.

Structure
REQ-034 Package mem_req_pkg SHALL hold the state enum and default TIMEOUT_CYCLES constant.
REQ-035 Wait counter SHALL be sub-module mem_req_timeout (clear, enable, expired output, width $clog2(TIMEOUT_CYCLES)).

Verification
REQ-036 Byte load 0x9997, memory 0x90, ack after 4 cycles -> rsp_valid one cycle, rsp_rdata=0x0090, rsp_err=0.
REQ-037 Half load 0x9985, data_output=0x3210 at ack -> rsp_rdata=0x3210; dbl_byte_en=1 throughout REQ.
REQ-038 Byte store 0x3333 to 0x9997 -> mem_write_en=1, data_in=0x3333 until ack; enables 0 in RELEASE; rsp_rdata=0.
REQ-039 Store to ROM 0x7775, no ack -> exactly TIMEOUT_CYCLES cycles in REQ, rsp_valid=1, rsp_err=1, then IDLE.
REQ-040 reset asserted 2 cycles into REQ -> next edge enables 0, req_ready=1, no rsp_valid; req_valid pulsed while busy -> no second request.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request unit: FSM states,
// the captured request payload and the load-data formatting helper.
package mem_req_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int unsigned ADDR_W                 = 16;
    localparam int unsigned DATA_W                 = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic              dbl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Byte loads return the low byte zero-extended; half loads return the full word.
    function automatic logic [DATA_W-1:0] fmt_load(input logic dbl, input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] res;
        if (dbl) res = raw;
        else     res = {8'h00, raw[7:0]};
        return res;
    endfunction

endpackage

// File: rtl/mem_req_timeout.sv
// Wait counter for an outstanding request; flags expiry when the count
// reaches TIMEOUT_CYCLES-1.
module mem_req_timeout
    import mem_req_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic hwclk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge hwclk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = (r_count == LAST);

endmodule

// File: rtl/mem_request_unit.sv
// CPU-side memory request sequencer: captures one request, presents it to the
// memory controller until ack or timeout, then pulses a one-cycle response.
module mem_request_unit
    import mem_req_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_dbl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic              dbl_byte_en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic              ack,
    input  logic [DATA_W-1:0] data_output
);

    state_t            r_state;
    state_t            w_next_state;
    req_t              r_hold;
    req_t              w_hold;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_mem_read_en;
    logic              r_mem_write_en;
    logic              r_dbl_byte_en;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data_in;

    logic              w_req_ready;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic              w_rsp_err;
    logic              w_mem_read_en;
    logic              w_mem_write_en;
    logic              w_dbl_byte_en;
    logic [ADDR_W-1:0] w_address;
    logic [DATA_W-1:0] w_data_in;

    logic              w_expired;
    logic              w_cnt_clear;
    logic              w_cnt_enable;

    assign w_cnt_clear  = (r_state != ST_REQ);
    assign w_cnt_enable = (r_state == ST_REQ) && !ack;

    mem_req_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .hwclk       (hwclk),
        .reset       (reset),
        .i_clear     (w_cnt_clear),
        .i_enable    (w_cnt_enable),
        .o_expired_c (w_expired)
    );

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and next output values; outputs describe the state being entered.
    always_comb begin
        w_next_state   = r_state;
        w_hold         = r_hold;
        w_req_ready    = 1'b0;
        w_rsp_valid    = 1'b0;
        w_rsp_rdata    = r_rsp_rdata;
        w_rsp_err      = r_rsp_err;
        w_mem_read_en  = 1'b0;
        w_mem_write_en = 1'b0;
        w_dbl_byte_en  = 1'b0;
        w_address      = '0;
        w_data_in      = '0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state   = ST_REQ;
                    w_hold.write   = req_write;
                    w_hold.dbl     = req_dbl;
                    w_hold.addr    = req_addr;
                    w_hold.wdata   = req_wdata;
                    w_mem_read_en  = !req_write;
                    w_mem_write_en = req_write;
                    w_dbl_byte_en  = req_dbl;
                    w_address      = req_addr;
                    w_data_in      = req_wdata;
                end else begin
                    w_req_ready = 1'b1;
                end
            end

            // Ack takes priority over a simultaneous timeout.
            ST_REQ: begin
                if (ack) begin
                    w_next_state = ST_RELEASE;
                    w_rsp_valid  = 1'b1;
                    w_rsp_err    = 1'b0;
                    w_rsp_rdata  = r_hold.write ? '0 : fmt_load(r_hold.dbl, data_output);
                end else if (w_expired) begin
                    w_next_state = ST_RELEASE;
                    w_rsp_valid  = 1'b1;
                    w_rsp_err    = 1'b1;
                    w_rsp_rdata  = '0;
                end else begin
                    w_mem_read_en  = !r_hold.write;
                    w_mem_write_en = r_hold.write;
                    w_dbl_byte_en  = r_hold.dbl;
                    w_address      = r_hold.addr;
                    w_data_in      = r_hold.wdata;
                end
            end

            ST_RELEASE: begin
                w_next_state = ST_IDLE;
                w_req_ready  = 1'b1;
            end

            default: begin
                w_next_state = ST_IDLE;
                w_req_ready  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_hold         <= '0;
            r_req_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_dbl_byte_en  <= 1'b0;
            r_address      <= '0;
            r_data_in      <= '0;
        end else begin
            r_hold         <= w_hold;
            r_req_ready    <= w_req_ready;
            r_rsp_valid    <= w_rsp_valid;
            r_rsp_rdata    <= w_rsp_rdata;
            r_rsp_err      <= w_rsp_err;
            r_mem_read_en  <= w_mem_read_en;
            r_mem_write_en <= w_mem_write_en;
            r_dbl_byte_en  <= w_dbl_byte_en;
            r_address      <= w_address;
            r_data_in      <= w_data_in;
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign mem_read_en  = r_mem_read_en;
    assign mem_write_en = r_mem_write_en;
    assign dbl_byte_en  = r_dbl_byte_en;
    assign address      = r_address;
    assign data_in      = r_data_in;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: loads, stores, timeout, ack/timeout
// race, reset abort and busy-time request rejection.
module tb_mem_request_unit;

    logic        hwclk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_dbl;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        dbl_byte_en;
    logic [15:0] address;
    logic [15:0] data_in;
    logic        ack;
    logic [15:0] data_output;

    int n_pass  = 0;
    int n_total = 0;

    mem_request_unit #(.TIMEOUT_CYCLES(16)) dut (
        .hwclk        (hwclk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_dbl      (req_dbl),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .dbl_byte_en  (dbl_byte_en),
        .address      (address),
        .data_in      (data_in),
        .ack          (ack),
        .data_output  (data_output)
    );

    always #5 hwclk = ~hwclk;

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic wr, input logic dbl, input logic [15:0] addr, input logic [15:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_dbl   = dbl;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 16'hFFFF;
        req_write = ~wr;
        req_dbl   = ~dbl;
    endtask

    int cnt;

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_dbl     = 1'b0;
        req_addr    = 16'h0000;
        req_wdata   = 16'h0000;
        ack         = 1'b0;
        data_output = 16'h0000;
        tick();
        tick();
        chk1 ("rst_ready",   req_ready,    1'b1);
        chk1 ("rst_rvalid",  rsp_valid,    1'b0);
        chk1 ("rst_rd_en",   mem_read_en,  1'b0);
        chk1 ("rst_wr_en",   mem_write_en, 1'b0);
        chk16("rst_addr",    address,      16'h0000);
        chk16("rst_rdata",   rsp_rdata,    16'h0000);
        reset = 1'b0;
        tick();

        // Byte load, ack after 4 cycles in REQ, upper byte of memory data masked
        issue(1'b0, 1'b0, 16'h9997, 16'h0000);
        chk1 ("bl_rd_en",   mem_read_en,  1'b1);
        chk1 ("bl_wr_en",   mem_write_en, 1'b0);
        chk1 ("bl_dbl",     dbl_byte_en,  1'b0);
        chk16("bl_addr",    address,      16'h9997);
        chk1 ("bl_ready",   req_ready,    1'b0);
        tick();
        tick();
        tick();
        chk1 ("bl_rd_en_hold", mem_read_en, 1'b1);
        chk16("bl_addr_hold",  address,     16'h9997);
        ack = 1'b1;
        data_output = 16'hAB90;
        tick();
        ack = 1'b0;
        data_output = 16'h0000;
        chk1 ("bl_rvalid",  rsp_valid,    1'b1);
        chk16("bl_rdata",   rsp_rdata,    16'h0090);
        chk1 ("bl_err",     rsp_err,      1'b0);
        chk1 ("bl_rel_rd",  mem_read_en,  1'b0);
        chk16("bl_rel_addr", address,     16'h0000);
        tick();
        chk1 ("bl_idle_rv",  rsp_valid,   1'b0);
        chk1 ("bl_idle_rdy", req_ready,   1'b1);
        chk16("bl_rd_held",  rsp_rdata,   16'h0090);

        // Ack while idle has no effect
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk1 ("idle_ack_rv",  rsp_valid, 1'b0);
        chk1 ("idle_ack_rdy", req_ready, 1'b1);

        // Half-word load
        issue(1'b0, 1'b1, 16'h9985, 16'h0000);
        chk1 ("hl_dbl0", dbl_byte_en, 1'b1);
        tick();
        chk1 ("hl_dbl1", dbl_byte_en, 1'b1);
        chk16("hl_addr", address,     16'h9985);
        ack = 1'b1;
        data_output = 16'h3210;
        tick();
        ack = 1'b0;
        chk1 ("hl_rvalid", rsp_valid,   1'b1);
        chk16("hl_rdata",  rsp_rdata,   16'h3210);
        chk1 ("hl_rel_dbl", dbl_byte_en, 1'b0);
        tick();

        // Byte store
        issue(1'b1, 1'b0, 16'h9997, 16'h3333);
        chk1 ("bs_wr_en", mem_write_en, 1'b1);
        chk1 ("bs_rd_en", mem_read_en,  1'b0);
        chk16("bs_din",   data_in,      16'h3333);
        tick();
        chk16("bs_din_hold", data_in,   16'h3333);
        ack = 1'b1;
        data_output = 16'hFFFF;
        tick();
        ack = 1'b0;
        chk1 ("bs_rvalid", rsp_valid,    1'b1);
        chk16("bs_rdata",  rsp_rdata,    16'h0000);
        chk1 ("bs_rel_wr", mem_write_en, 1'b0);
        chk16("bs_rel_din", data_in,     16'h0000);
        tick();

        // Store to ROM with no ack: timeout after exactly 16 cycles in REQ
        issue(1'b1, 1'b0, 16'h7775, 16'h1234);
        cnt = 0;
        while (mem_write_en && cnt < 40) begin
            cnt++;
            tick();
        end
        chk16("to_cycles", 16'(cnt), 16'd16);
        chk1 ("to_rvalid", rsp_valid, 1'b1);
        chk1 ("to_err",    rsp_err,   1'b1);
        chk16("to_rdata",  rsp_rdata, 16'h0000);
        tick();
        chk1 ("to_idle_rdy", req_ready, 1'b1);
        chk1 ("to_idle_rv",  rsp_valid, 1'b0);
        chk1 ("to_err_held", rsp_err,   1'b1);

        // Ack on the same edge the timeout would fire: ack wins
        issue(1'b0, 1'b0, 16'h0100, 16'h0000);
        for (int i = 0; i < 15; i++) tick();
        chk1 ("race_still_req", mem_read_en, 1'b1);
        ack = 1'b1;
        data_output = 16'h5542;
        tick();
        ack = 1'b0;
        chk1 ("race_rvalid", rsp_valid, 1'b1);
        chk1 ("race_err",    rsp_err,   1'b0);
        chk16("race_rdata",  rsp_rdata, 16'h0042);
        tick();

        // Reset two cycles into REQ aborts without a response
        issue(1'b0, 1'b1, 16'h2222, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1 ("rr_rd_en", mem_read_en, 1'b0);
        chk1 ("rr_dbl",   dbl_byte_en, 1'b0);
        chk1 ("rr_ready", req_ready,   1'b1);
        chk1 ("rr_rv",    rsp_valid,   1'b0);
        chk16("rr_addr",  address,     16'h0000);
        tick();
        chk1 ("rr_rv2",   rsp_valid,   1'b0);

        // req_valid while busy is ignored
        issue(1'b0, 1'b0, 16'h4444, 16'h0000);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h1234;
        tick();
        chk1 ("busy_ready", req_ready,    1'b0);
        chk16("busy_addr",  address,      16'h4444);
        chk1 ("busy_wr",    mem_write_en, 1'b0);
        req_valid = 1'b0;
        ack = 1'b1;
        data_output = 16'h0077;
        tick();
        ack = 1'b0;
        chk1 ("busy_rvalid", rsp_valid, 1'b1);
        chk16("busy_rdata",  rsp_rdata, 16'h0077);
        tick();
        chk1 ("busy_idle_rdy", req_ready,   1'b1);
        chk1 ("busy_no_rd",    mem_read_en, 1'b0);
        tick();
        chk1 ("busy_no_wr",    mem_write_en, 1'b0);
        chk1 ("busy_still_rdy", req_ready,   1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
